// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: registered reads with write-first bypass
// and a one-entry-per-cycle clear sweep. Optional macro REGFILE_R0_ZERO_EN hardwires entry 0 to zero.
module register_file_mp #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 64,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear_req,
    input  logic [NUM_RD-1:0]          read_en,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    input  logic [NUM_WR-1:0]          write_en,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rvalid,
    output logic                       init_done
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [ADDR_W:0]   DEPTH_L   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    state_e                     state_q;
    state_e                     state_d;
    logic [ADDR_W-1:0]          ptr_q;
    logic [ADDR_W-1:0]          ptr_d;
    logic                       init_done_q;
    logic                       init_done_d;
    logic [NUM_RD*DATA_W-1:0]   rdata_q;
    logic [NUM_RD-1:0]          rvalid_q;

    logic [DATA_W-1:0]          RF [0:DEPTH-1];

    logic                       active_s;
    logic                       clearing_s;
    logic [NUM_WR-1:0]          wr_ok_s;
    logic [NUM_RD-1:0]          rd_fire_s;
    logic [DATA_W-1:0]          rd_val_s [NUM_RD];

    // DEPTH need not be a power of two, so the top of the address space is unbacked
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic addr_backed(input logic [ADDR_W-1:0] a);
        return addr_in_range(a) && !(R0_ZERO && (a == ZERO_ADDR));
    endfunction

    // Qualify per-port write and read strobes against state and address range
    always_comb begin
        active_s   = reset_n && (state_q == ST_READY);
        clearing_s = reset_n && (state_q == ST_CLEAR);
        wr_ok_s    = {NUM_WR{1'b0}};
        rd_fire_s  = {NUM_RD{1'b0}};
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok_s[w] = active_s && write_en[w] && addr_backed(waddr[w*ADDR_W +: ADDR_W]);
        end
        for (int p = 0; p < NUM_RD; p++) begin
            rd_fire_s[p] = active_s && read_en[p];
        end
    end

    // Read data with write-first bypass; later write ports override earlier ones
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val_s[p] = {DATA_W{1'b0}};
            if (addr_backed(raddr[p*ADDR_W +: ADDR_W])) begin
                rd_val_s[p] = RF[raddr[p*ADDR_W +: ADDR_W]];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok_s[w] && (waddr[w*ADDR_W +: ADDR_W] == raddr[p*ADDR_W +: ADDR_W])) begin
                        rd_val_s[p] = wdata[w*DATA_W +: DATA_W];
                    end else begin
                        rd_val_s[p] = rd_val_s[p];
                    end
                end
            end else begin
                rd_val_s[p] = {DATA_W{1'b0}};
            end
        end
    end

    // Clear-sweep / ready sequencing
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d     = ST_READY;
                    ptr_d       = ZERO_ADDR;
                    init_done_d = 1'b1;
                end else begin
                    ptr_d       = ptr_q + ONE_ADDR;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    ptr_d       = ZERO_ADDR;
                    init_done_d = 1'b0;
                end else begin
                    state_d     = ST_READY;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                ptr_d       = ZERO_ADDR;
                init_done_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= ZERO_ADDR;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage array: not reset, cleared by the sweep; ascending loop lets the highest port win
    always_ff @(posedge clk) begin
        if (clearing_s) begin
            RF[ptr_q] <= {DATA_W{1'b0}};
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok_s[w]) begin
                    RF[waddr[w*ADDR_W +: ADDR_W]] <= wdata[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Registered read ports; rdata holds when a port is idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q  <= {(NUM_RD*DATA_W){1'b0}};
            rvalid_q <= {NUM_RD{1'b0}};
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rvalid_q[p] <= rd_fire_s[p];
                if (rd_fire_s[p]) begin
                    rdata_q[p*DATA_W +: DATA_W] <= rd_val_s[p];
                end
            end
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp (DEPTH=48, 2 read / 2 write ports), with a
// behavioural array model; honours REGFILE_R0_ZERO_EN when defined.
module tb_register_file_mp;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 48;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 6;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      clear_req;
    logic [NUM_RD-1:0]         read_en;
    logic [NUM_RD*AW-1:0]      raddr;
    logic [NUM_WR-1:0]         write_en;
    logic [NUM_WR*AW-1:0]      waddr;
    logic [NUM_WR*DATA_W-1:0]  wdata;
    logic [NUM_RD*DATA_W-1:0]  rdata;
    logic [NUM_RD-1:0]         rvalid;
    logic                      init_done;

    register_file_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
        .read_en(read_en), .raddr(raddr),
        .write_en(write_en), .waddr(waddr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        int unsigned tag;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_q[$];
    bit          rst_at[int unsigned];
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [63:0] model_rf [DEPTH];
    bit          m_ready = 1'b0;
    int          m_idx   = 0;
    logic [63:0] last_val [NUM_RD];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Reference model: writes land first (ascending port order), then reads see the array.
    task automatic model_step();
        int a;
        logic [63:0] v;
        exp_t e;
        if (!reset_n) begin
            m_ready = 1'b0;
            m_idx   = 0;
            rst_at[edge_cnt + 1] = 1'b1;
        end else if (!m_ready) begin
            model_rf[m_idx] = 64'h0;
            m_idx++;
            if (m_idx == DEPTH) m_ready = 1'b1;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                a = int'(waddr[w*AW +: AW]);
                if (write_en[w] && a < DEPTH && !(R0 && a == 0)) model_rf[a] = wdata[w*DATA_W +: DATA_W];
            end
            for (int p = 0; p < NUM_RD; p++) begin
                if (read_en[p]) begin
                    a = int'(raddr[p*AW +: AW]);
                    v = (a < DEPTH) ? model_rf[a] : 64'h0;
                    if (R0 && a == 0) v = 64'h0;
                    e.port = p; e.tag = edge_cnt + 1; e.data = v;
                    sb_q.push_back(e);
                end
            end
            if (clear_req) begin
                m_ready = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    // Monitor: pops the expectation tagged for the edge just taken whenever a port presents rvalid
    always @(negedge clk) begin
        int unsigned cur;
        int found;
        if (edge_cnt >= 1) begin
            cur = edge_cnt;
            if (rst_at.exists(cur)) begin
                for (int p = 0; p < NUM_RD; p++) last_val[p] = 64'h0;
            end
            for (int p = 0; p < NUM_RD; p++) begin
                found = -1;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (found < 0 && sb_q[i].port == p && sb_q[i].tag == cur) found = i;
                end
                if (rvalid[p]) begin
                    if (found < 0) begin
                        chk($sformatf("rvalid%0d_unexpected", p), {63'h0, rvalid[p]}, 64'h0);
                    end else begin
                        chk($sformatf("rdata%0d", p), rdata[p*DATA_W +: DATA_W], sb_q[found].data);
                        last_val[p] = sb_q[found].data;
                        sb_q.delete(found);
                    end
                end else if (found >= 0) begin
                    chk($sformatf("rvalid%0d_missing", p), {63'h0, rvalid[p]}, 64'h1);
                    sb_q.delete(found);
                end else begin
                    chk($sformatf("rdata%0d_hold", p), rdata[p*DATA_W +: DATA_W], last_val[p]);
                end
            end
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("init_done", {63'h0, init_done}, {63'h0, m_ready});
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        read_en   = '0;
        write_en  = '0;
        raddr     = '0;
        waddr     = '0;
        wdata     = '0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [63:0] d);
        write_en[w]              = 1'b1;
        waddr[w*AW +: AW]        = AW'(a);
        wdata[w*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        read_en[p]        = 1'b1;
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic rand_inputs(input bit allow_clear);
        idle_inputs();
        clear_req = allow_clear && ($urandom_range(0, 59) == 0);
        for (int w = 0; w < NUM_WR; w++) begin
            if ($urandom_range(0, 1) == 1)
                set_wr(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63),
                       {$urandom, $urandom});
        end
        for (int p = 0; p < NUM_RD; p++) begin
            if ($urandom_range(0, 1) == 1)
                set_rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63));
        end
    endtask

    task automatic check_rf();
        for (int i = 0; i < DEPTH; i++) chk($sformatf("rf[%0d]", i), dut.RF[i], model_rf[i]);
    endtask

    task automatic sweep_from_release(input string name);
        int n;
        n = 0;
        while (!init_done && n < 4 * DEPTH) begin
            rand_inputs(1'b0);
            cycle();
            n++;
        end
        chk(name, 64'(n), 64'(DEPTH));
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (10) cycle();

        reset_n = 1'b1;
        sweep_from_release("sweep_len_initial");
        check_rf();

        // Write then read on another port next cycle
        set_wr(0, 5, 64'hDEAD_BEEF);
        cycle();
        idle_inputs();
        set_rd(1, 5);
        cycle();
        idle_inputs();
        cycle();

        // Same-edge bypass to two read ports
        set_wr(0, 9, 64'h1234);
        set_rd(0, 9);
        set_rd(1, 9);
        cycle();
        idle_inputs();
        cycle();

        // Two write ports on the same address, highest port wins
        set_wr(0, 3, 64'hA);
        set_wr(1, 3, 64'hB);
        set_rd(0, 3);
        cycle();
        idle_inputs();
        cycle();
        chk("rf3_port_priority", dut.RF[3], 64'hB);

        // Out-of-range write dropped, out-of-range read returns zero
        set_wr(1, 50, 64'h5555_5555);
        set_rd(0, 50);
        cycle();
        idle_inputs();
        cycle();
        check_rf();

        // Entry 0 behaviour
        set_wr(0, 0, 64'h77);
        cycle();
        idle_inputs();
        set_rd(0, 0);
        cycle();
        idle_inputs();
        set_wr(1, 0, 64'h77);
        set_rd(1, 0);
        cycle();
        idle_inputs();
        cycle();
        chk("rf0", dut.RF[0], R0 ? 64'h0 : 64'h77);

        // Fill, request clear (with a same-cycle read), interrupt the sweep with reset
        for (int a = 0; a < DEPTH; a++) begin
            idle_inputs();
            set_wr(0, a, 64'hFF);
            cycle();
        end
        idle_inputs();
        clear_req = 1'b1;
        set_rd(0, 7);
        cycle();
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0);
            cycle();
        end
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        sweep_from_release("sweep_len_restart");
        check_rf();

        // Randomised traffic with occasional clear requests
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH + 2 && !m_ready; i++) cycle();
        cycle();
        check_rf();
        chk("scoreboard_drain", 64'(sb_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
